serial_slice_adder: RTL and testbench

- Multi-cycle add/subtract unit, generalised from the single-bit full adder.
- Processes a WIDTH-bit operand pair SLICE bits per clock through an internal SLICE-bit ripple-carry chain.
- Start/busy/done handshake; carry-in; add or subtract mode; unsigned carry-out and signed overflow flags.
- Serves as the area-cheap arithmetic datapath for the multi-bit structural designs built on the full adder.

---
 rtl/serial_slice_adder_if.sv | 26 ++
 rtl/serial_slice_adder.sv | 122 ++++++++++++
 tb/tb_serial_slice_adder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_slice_adder_if.sv
// Handshake and operand/result bundle for the serial slice adder.
// The master side issues operations; the slave side (the adder) answers.
interface serial_slice_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_slice_adder.sv
// Multi-cycle add/subtract unit: walks a WIDTH-bit operand pair through a
// SLICE-bit ripple-carry chain, one slice per clock, LSB slice first.
// Subtraction is done as A + ~B + !cin, so cout=1 means "no borrow".
module serial_slice_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input logic                clk,
  input logic                rst,
  serial_slice_adder_if.slave bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] sum_reg;
  logic             carry;
  logic [CW-1:0]    count;
  logic             cout_reg;
  logic             ovf_reg;

  logic [SLICE:0]   chain;
  logic [SLICE-1:0] slice_sum;
  logic             last;

  // Ripple the current low slice of A and B' through the carry chain and
  // pre-compute the shifted accumulator (new slice enters at the MSB end).
  always_comb begin
    chain     = '0;
    slice_sum = '0;
    chain[0]  = carry;
    for (int i = 0; i < SLICE; i++) begin
      slice_sum[i] = a_reg[i] ^ b_reg[i] ^ chain[i];
      chain[i+1]   = (a_reg[i] & b_reg[i]) | (chain[i] & (a_reg[i] ^ b_reg[i]));
    end
    acc_next = (WIDTH'(slice_sum) << (WIDTH - SLICE)) | (acc >> SLICE);
    last     = (count == CW'(N - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, leave RUN after the last slice,
  // DONE lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, shift one slice per RUN cycle,
  // and publish sum/flags only on the final slice so they hold between ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      count    <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg <= bus.a;
            b_reg <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.cin ^ bus.sub;
            count <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          a_reg <= a_reg >> SLICE;
          b_reg <= b_reg >> SLICE;
          carry <= chain[SLICE];
          acc   <= acc_next;
          if (last) begin
            count    <= '0;
            sum_reg  <= acc_next;
            cout_reg <= chain[SLICE];
            ovf_reg  <= chain[SLICE] ^ chain[SLICE-1];
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_slice_adder.sv
// Self-checking bench for serial_slice_adder: an 8-bit/1-bit-slice instance
// and a 16-bit/4-bit-slice instance checked against an arithmetic model.
module tb_serial_slice_adder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  serial_slice_adder_if #(.WIDTH(8))  bus8 ();
  serial_slice_adder_if #(.WIDTH(16)) bus16 ();

  serial_slice_adder #(.WIDTH(8), .SLICE(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_slice_adder #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on A, B and cin.
  function automatic void model(input int w, input longint ua, input longint ub,
                                input bit cin, input bit sub,
                                output longint s, output bit co, output bit ov);
    longint m, half, sa, sb, ures, sres;
    m    = longint'(1) << w;
    half = m >> 1;
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (!sub) begin
      ures = ua + ub + longint'(cin);
      co   = (ures >= m);
      sres = sa + sb + longint'(cin);
    end else begin
      ures = ua - ub - longint'(cin);
      co   = (ures >= 0);
      sres = sa - sb - longint'(cin);
    end
    ov = (sres < -half) || (sres >= half);
    s  = ures & (m - 1);
  endfunction

  task automatic driveBus(input int cfg, input logic st, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic sub);
    if (cfg == 0) begin
      bus8.start = st;
      bus8.a     = a[7:0];
      bus8.b     = b[7:0];
      bus8.cin   = cin;
      bus8.sub   = sub;
    end else begin
      bus16.start = st;
      bus16.a     = a;
      bus16.b     = b;
      bus16.cin   = cin;
      bus16.sub   = sub;
    end
  endtask

  function automatic longint getSum(input int cfg);
    return (cfg == 0) ? longint'(bus8.sum) : longint'(bus16.sum);
  endfunction

  function automatic logic getBusy(input int cfg);
    return (cfg == 0) ? bus8.busy : bus16.busy;
  endfunction

  function automatic logic getDone(input int cfg);
    return (cfg == 0) ? bus8.done : bus16.done;
  endfunction

  function automatic logic getCout(input int cfg);
    return (cfg == 0) ? bus8.cout : bus16.cout;
  endfunction

  function automatic logic getOvf(input int cfg);
    return (cfg == 0) ? bus8.ovf : bus16.ovf;
  endfunction

  // Present an operation for one accepting edge, then scramble the inputs.
  task automatic startOp(input int cfg, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
    @(negedge clk);
    driveBus(cfg, 1'b1, a, b, cin, sub);
    @(posedge clk);
    #1;
    driveBus(cfg, 1'b0, ~a, 16'($urandom), ~cin, ~sub);
  endtask

  // Count edges until done (edges = -1 on timeout) and busy samples before it.
  task automatic waitDone(input int cfg, input int max_edges, output int edges, output int busy_cycles);
    bit seen;
    seen        = 1'b0;
    edges       = 0;
    busy_cycles = getBusy(cfg) ? 1 : 0;
    while (edges < max_edges) begin
      @(posedge clk);
      #1;
      edges++;
      if (getDone(cfg)) begin
        seen = 1'b1;
        break;
      end
      if (getBusy(cfg)) busy_cycles++;
    end
    if (!seen) edges = -1;
  endtask

  // One full operation with result, latency, busy-width and pulse-width checks.
  task automatic applyStimulus(input int cfg, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub);
    int     w, n, e, bc;
    longint s;
    bit     co, ov;
    w = (cfg == 0) ? 8 : 16;
    n = (cfg == 0) ? 8 : 4;
    model(w, longint'(a), longint'(b), cin, sub, s, co, ov);
    startOp(cfg, a, b, cin, sub);
    waitDone(cfg, 4 * n, e, bc);
    checkOutput("latency", longint'(e), longint'(n));
    checkOutput("busy_cycles", longint'(bc), longint'(n));
    checkOutput("sum", getSum(cfg), s);
    checkOutput("cout", longint'(getCout(cfg)), longint'(co));
    checkOutput("ovf", longint'(getOvf(cfg)), longint'(ov));
    @(posedge clk);
    #1;
    checkOutput("done_width", longint'(getDone(cfg)), 0);
  endtask

  task automatic checkCleared(input int cfg, input string tag);
    checkOutput({tag, "_busy"}, longint'(getBusy(cfg)), 0);
    checkOutput({tag, "_done"}, longint'(getDone(cfg)), 0);
    checkOutput({tag, "_sum"}, getSum(cfg), 0);
    checkOutput({tag, "_cout"}, longint'(getCout(cfg)), 0);
    checkOutput({tag, "_ovf"}, longint'(getOvf(cfg)), 0);
  endtask

  // Directed steps followed by randomized runs on both instances.
  initial begin
    int e, bc, pulses, busies;
    rst = 1'b1;
    driveBus(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    driveBus(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #2;
    checkCleared(0, "reset8");
    checkCleared(1, "reset16");
    @(negedge clk);
    rst = 1'b0;

    // Basic add, unsigned and signed overflow edges.
    applyStimulus(0, 16'h35, 16'h4A, 1'b0, 1'b0);
    applyStimulus(0, 16'hFF, 16'h01, 1'b0, 1'b0);
    applyStimulus(0, 16'h7F, 16'h01, 1'b0, 1'b0);
    // Subtract cases including borrow and signed overflow.
    applyStimulus(0, 16'h10, 16'h20, 1'b0, 1'b1);
    applyStimulus(0, 16'h80, 16'h01, 1'b0, 1'b1);
    applyStimulus(0, 16'h05, 16'h02, 1'b1, 1'b1);

    // Start pulsed mid-run must be ignored; result from the original operands.
    startOp(0, 16'h12, 16'h34, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    driveBus(0, 1'b1, 16'hAA, 16'h55, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    driveBus(0, 1'b0, 16'h00, 16'h00, 1'b0, 1'b0);
    waitDone(0, 40, e, bc);
    checkOutput("hs_done_seen", longint'(e > 0), 1);
    checkOutput("hs_sum", getSum(0), 64'h46);
    checkOutput("hs_cout", longint'(getCout(0)), 0);
    pulses = 0;
    busies = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (getDone(0)) pulses++;
      if (getBusy(0)) busies++;
    end
    checkOutput("hs_extra_done", longint'(pulses), 0);
    checkOutput("hs_restart_busy", longint'(busies), 0);

    // Asynchronous reset partway through a run aborts it with no done pulse.
    startOp(0, 16'h77, 16'h11, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkCleared(0, "midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    busies = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (getDone(0)) pulses++;
      if (getBusy(0)) busies++;
    end
    checkOutput("midrst_done", longint'(pulses), 0);
    checkOutput("midrst_busy", longint'(busies), 0);
    applyStimulus(0, 16'h77, 16'h11, 1'b0, 1'b0);

    // Wide instance with 4-bit slices.
    applyStimulus(1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1, 16'h8000, 16'h0001, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                    1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
